// File: rtl/cart_rtc.sv
// cart_rtc: shared cartridge real-time clock with latched register view and save/restore.
// Offline catch-up engine is present only when CART_RTC_CATCHUP_EN is defined.
module cart_rtc #(
   parameter int CLK_HZ   = 33554432,
   parameter int DAY_BITS = 9,
   parameter int STATE_W  = DAY_BITS + 19
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               ce,
   input  logic [2:0]         reg_sel,
   input  logic               wr,
   input  logic [7:0]         wdata,
   output logic [7:0]         rdata,
   input  logic               latch_wr,
   input  logic               latch_in,
   input  logic               ld_valid,
   input  logic [STATE_W-1:0] ld_state,
   input  logic [31:0]        ld_elapsed,
   output logic [STATE_W-1:0] save_state,
   output logic               busy,
   output logic               sec_pulse
);

   localparam int SUB_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CLK_HZ - 1);
   localparam int DH_W = DAY_BITS - 8;

   logic [SUB_W-1:0]    r_sub;
   logic [5:0]          r_sec;
   logic [5:0]          r_min;
   logic [4:0]          r_hour;
   logic [DAY_BITS-1:0] r_day;
   logic                r_halt;
   logic                r_ovf;

   logic                r_lbit;
   logic [5:0]          r_l_sec;
   logic [5:0]          r_l_min;
   logic [4:0]          r_l_hour;
   logic [DAY_BITS-1:0] r_l_day;
   logic                r_l_ovf;

   logic [STATE_W-1:0]  r_save;
   logic                r_pulse;

   logic                w_wr;
   logic                w_tick;
   logic                w_step;
   logic                w_busy;
   logic                w_adv;
   logic [STATE_W-1:0]  w_live;

   logic [5:0]          w_ld_sec;
   logic [5:0]          w_ld_min;
   logic [4:0]          w_ld_hour;
   logic [DAY_BITS-1:0] w_ld_day;
   logic                w_ld_ovf;
   logic                w_ld_halt;

   logic                w_c_sec;
   logic                w_c_min;
   logic                w_c_hour;
   logic [5:0]          w_n_sec;
   logic [5:0]          w_n_min;
   logic [4:0]          w_n_hour;
   logic [DAY_BITS-1:0] w_n_day;
   logic                w_n_ovf;
   logic [7:0]          w_dhi;

   assign w_ld_sec  = ld_state[5:0];
   assign w_ld_min  = ld_state[11:6];
   assign w_ld_hour = ld_state[16:12];
   assign w_ld_day  = ld_state[17 +: DAY_BITS];
   assign w_ld_ovf  = ld_state[DAY_BITS+17];
   assign w_ld_halt = ld_state[DAY_BITS+18];

   assign w_live = {r_halt, r_ovf, r_day, r_hour, r_min, r_sec};
   assign w_wr   = ce & wr & (reg_sel < 3'd6);
   assign w_tick = ~r_halt & (r_sub == SUB_MAX);
   assign w_step = w_busy & ~w_tick & ~w_wr & ~r_halt;
   assign w_adv  = w_tick | w_step;

   // Out-of-range values (60-63, 24-31) roll to 0 without carrying.
   always_comb begin
      w_c_sec  = (r_sec == 6'd59);
      w_n_sec  = w_c_sec ? 6'd0 : r_sec + 6'd1;
      w_c_min  = w_c_sec & (r_min == 6'd59);
      w_n_min  = r_min;
      if (w_c_sec)
         w_n_min = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
      w_c_hour = w_c_min & (r_hour == 5'd23);
      w_n_hour = r_hour;
      if (w_c_min)
         w_n_hour = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
      w_n_day  = w_c_hour ? r_day + DAY_BITS'(1) : r_day;
      w_n_ovf  = r_ovf | (w_c_hour & (&r_day));
   end

`ifdef CART_RTC_CATCHUP_EN
   logic [31:0] r_pend;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         r_pend <= '0;
      else if (ld_valid)
         r_pend <= w_ld_halt ? 32'd0 : ld_elapsed;
      else if (w_step)
         r_pend <= r_pend - 32'd1;
   end

   assign w_busy = (r_pend != 32'd0);
`else
   logic w_unused;
   assign w_unused = ^ld_elapsed;
   assign w_busy   = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         r_sub <= '0;
      else if (ld_valid)
         r_sub <= '0;
      else if (w_wr && reg_sel == 3'd0)
         r_sub <= '0;
      else if (!r_halt)
         r_sub <= (r_sub == SUB_MAX) ? '0 : r_sub + SUB_W'(1);
   end

   // Load beats write beats real tick beats catch-up step.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_sec  <= '0;
         r_min  <= '0;
         r_hour <= '0;
         r_day  <= '0;
         r_halt <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (ld_valid) begin
         r_sec  <= w_ld_sec;
         r_min  <= w_ld_min;
         r_hour <= w_ld_hour;
         r_day  <= w_ld_day;
         r_halt <= w_ld_halt;
         r_ovf  <= w_ld_ovf;
      end else if (w_wr) begin
         case (reg_sel)
            3'd0: r_sec <= wdata[5:0];
            3'd1: r_min <= wdata[5:0];
            3'd2: r_hour <= wdata[4:0];
            3'd3: r_day[7:0] <= wdata;
            3'd4: begin
               r_day[8] <= wdata[0];
               r_halt   <= wdata[6];
               r_ovf    <= wdata[7];
            end
            default: r_day[DAY_BITS-1:8] <= wdata[DH_W-1:0];
         endcase
      end else if (w_adv) begin
         r_sec  <= w_n_sec;
         r_min  <= w_n_min;
         r_hour <= w_n_hour;
         r_day  <= w_n_day;
         r_ovf  <= w_n_ovf;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_lbit   <= 1'b0;
         r_l_sec  <= '0;
         r_l_min  <= '0;
         r_l_hour <= '0;
         r_l_day  <= '0;
         r_l_ovf  <= 1'b0;
      end else if (ce && latch_wr) begin
         r_lbit <= latch_in;
         if (latch_in && !r_lbit) begin
            r_l_sec  <= r_sec;
            r_l_min  <= r_min;
            r_l_hour <= r_hour;
            r_l_day  <= r_day;
            r_l_ovf  <= r_ovf;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_save  <= '0;
         r_pulse <= 1'b0;
      end else begin
         if (!w_busy)
            r_save <= w_live;
         r_pulse <= ~ld_valid & ~w_wr & w_adv;
      end
   end

   always_comb begin
      w_dhi = 8'd0;
      w_dhi[DH_W-1:0] = r_l_day[DAY_BITS-1:8];
      case (reg_sel)
         3'd0:    rdata = {2'b00, r_l_sec};
         3'd1:    rdata = {2'b00, r_l_min};
         3'd2:    rdata = {3'b000, r_l_hour};
         3'd3:    rdata = r_l_day[7:0];
         3'd4:    rdata = {r_l_ovf, r_halt, 5'b00000, r_l_day[8]};
         3'd5:    rdata = w_dhi;
         default: rdata = 8'hFF;
      endcase
   end

   assign save_state = r_save;
   assign busy       = w_busy;
   assign sec_pulse  = r_pulse;

endmodule

// File: tb/tb_cart_rtc.sv
// tb_cart_rtc: directed checks of cart_rtc with CLK_HZ=4, DAY_BITS=9.
module tb_cart_rtc;

   localparam int HZ = 4;
   localparam int DB = 9;
   localparam int SW = DB + 19;

   logic          clk;
   logic          rst_n;
   logic          ce;
   logic [2:0]    reg_sel;
   logic          wr;
   logic [7:0]    wdata;
   logic [7:0]    rdata;
   logic          latch_wr;
   logic          latch_in;
   logic          ld_valid;
   logic [SW-1:0] ld_state;
   logic [31:0]   ld_elapsed;
   logic [SW-1:0] save_state;
   logic          busy;
   logic          sec_pulse;

   int n_tot = 0;
   int n_bad = 0;

   cart_rtc #(.CLK_HZ(HZ), .DAY_BITS(DB)) u_dut (
      .clk_sys   (clk),
      .reset_n   (rst_n),
      .ce        (ce),
      .reg_sel   (reg_sel),
      .wr        (wr),
      .wdata     (wdata),
      .rdata     (rdata),
      .latch_wr  (latch_wr),
      .latch_in  (latch_in),
      .ld_valid  (ld_valid),
      .ld_state  (ld_state),
      .ld_elapsed(ld_elapsed),
      .save_state(save_state),
      .busy      (busy),
      .sec_pulse (sec_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [SW-1:0] mk(input logic h, input logic o,
      input logic [8:0] d, input logic [4:0] hr,
      input logic [5:0] m, input logic [5:0] s);
      return {h, o, d, hr, m, s};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [SW-1:0] st, input logic [31:0] el);
      ld_state   = st;
      ld_elapsed = el;
      ld_valid   = 1'b1;
      @(negedge clk);
      ld_valid   = 1'b0;
   endtask

   task automatic wreg(input logic [2:0] s, input logic [7:0] d);
      reg_sel = s;
      wdata   = d;
      wr      = 1'b1;
      @(negedge clk);
      wr      = 1'b0;
   endtask

   task automatic latch(input logic b);
      latch_in = b;
      latch_wr = 1'b1;
      @(negedge clk);
      latch_wr = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [2:0] s,
                     input logic [7:0] e);
      reg_sel = s;
      #1;
      chk(tag, {24'd0, rdata}, {24'd0, e});
   endtask

   initial begin
      int k;
      rst_n      = 1'b0;
      ce         = 1'b1;
      reg_sel    = 3'd0;
      wr         = 1'b0;
      wdata      = 8'd0;
      latch_wr   = 1'b0;
      latch_in   = 1'b0;
      ld_valid   = 1'b0;
      ld_state   = '0;
      ld_elapsed = 32'd0;

      #1;
      chk("rst_save", save_state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulse", sec_pulse, 0);
      for (int s = 0; s < 8; s++)
         rd("rst_rdata", 3'(s), (s < 6) ? 8'h00 : 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1);

      // Full rollover 23:59:59 day 511 -> 00:00:00 day 0 with ovf
      load(mk(0, 0, 9'd511, 5'd23, 6'd59, 6'd59), 32'd0);
      latch(1'b0);
      latch(1'b1);
      rd("ro_l_day", 3'd3, 8'hFF);
      rd("ro_l_dhi", 3'd5, 8'h01);
      rd("ro_l_r4", 3'd4, 8'h01);
      rd("ro_l_hr", 3'd2, 8'd23);
      rd("ro_l_sec", 3'd0, 8'd59);
      cyc(1);
      chk("ro_pulse_pre", sec_pulse, 0);
      chk("ro_save_pre", save_state, mk(0, 0, 9'd511, 5'd23, 6'd59, 6'd59));
      cyc(1);
      chk("ro_pulse", sec_pulse, 1);
      cyc(1);
      chk("ro_pulse_end", sec_pulse, 0);
      chk("ro_save", save_state, mk(0, 1, 9'd0, 5'd0, 6'd0, 6'd0));
      latch(1'b0);
      latch(1'b1);
      rd("ro_sec", 3'd0, 8'h00);
      rd("ro_r4", 3'd4, 8'h80);
      rd("ro_day", 3'd3, 8'h00);
      rd("ro_dhi", 3'd5, 8'h00);

      // sec 63 rolls to 0 without carry
      load(mk(0, 0, 9'd5, 5'd2, 6'd10, 6'd0), 32'd0);
      wreg(3'd0, 8'd63);
      cyc(3);
      chk("s63_pre", save_state, mk(0, 0, 9'd5, 5'd2, 6'd10, 6'd63));
      cyc(2);
      chk("s63_wrap", save_state, mk(0, 0, 9'd5, 5'd2, 6'd10, 6'd0));

      // hour 31 with carry in rolls to 0 without day carry
      load(mk(0, 0, 9'd7, 5'd0, 6'd59, 6'd59), 32'd0);
      wreg(3'd2, 8'd31);
      cyc(2);
      chk("h31_pre", save_state, mk(0, 0, 9'd7, 5'd31, 6'd59, 6'd59));
      cyc(2);
      chk("h31_wrap", save_state, mk(0, 0, 9'd7, 5'd0, 6'd0, 6'd0));

      // Write coinciding with a tick wins; masked to field width
      load(mk(0, 0, 9'd0, 5'd1, 6'd2, 6'd3), 32'd0);
      cyc(3);
      wreg(3'd1, 8'hEA);
      chk("wt_pulse", sec_pulse, 0);
      cyc(1);
      chk("wt_state", save_state, mk(0, 0, 9'd0, 5'd1, 6'd42, 6'd3));

      // Latch edge detect, latch-on-tick, live halt in reg 4
      load(mk(0, 0, 9'd0, 5'd0, 6'd0, 6'd10), 32'd0);
      latch(1'b0);
      latch(1'b1);
      cyc(11);
      rd("lt_hold", 3'd0, 8'd10);
      latch(1'b1);
      rd("lt_norelatch", 3'd0, 8'd10);
      latch(1'b0);
      latch(1'b1);
      rd("lt_pretick", 3'd0, 8'd13);
      rd("lt_r4", 3'd4, 8'h00);
      wreg(3'd4, 8'h40);
      rd("lt_halt", 3'd4, 8'h40);
      cyc(3);
      chk("halt_state", save_state, mk(1, 0, 9'd0, 5'd0, 6'd0, 6'd14));
      cyc(8);
      chk("halt_frozen", save_state, mk(1, 0, 9'd0, 5'd0, 6'd0, 6'd14));
      chk("halt_pulse", sec_pulse, 0);

      // Load with halt set discards elapsed time
      load(mk(1, 0, 9'd3, 5'd4, 6'd5, 6'd6), 32'd100);
      chk("hl_busy0", busy, 0);
      cyc(20);
      chk("hl_busy", busy, 0);
      chk("hl_state", save_state, mk(1, 0, 9'd3, 5'd4, 6'd5, 6'd6));

`ifdef CART_RTC_CATCHUP_EN
      // 3661 steps interleaved with real ticks every 4th cycle: 4881 cycles
      load(mk(0, 0, 9'd0, 5'd0, 6'd0, 6'd0), 32'd3661);
      chk("cu_busy0", busy, 1);
      cyc(100);
      chk("cu_busy", busy, 1);
      chk("cu_save_hold", save_state, mk(1, 0, 9'd3, 5'd4, 6'd5, 6'd6));
      k = 100;
      while (busy && k < 6000) begin
         @(negedge clk);
         k++;
      end
      chk("cu_len", k, 4881);
      chk("cu_save_late", save_state, mk(1, 0, 9'd3, 5'd4, 6'd5, 6'd6));
      cyc(1);
      chk("cu_save", save_state, mk(0, 0, 9'd0, 5'd1, 6'd21, 6'd21));
`else
      k = 0;
      load(mk(0, 0, 9'd2, 5'd0, 6'd0, 6'd0), 32'd3661);
      chk("nc_busy", busy, k);
      cyc(1);
      chk("nc_save", save_state, mk(0, 0, 9'd2, 5'd0, 6'd0, 6'd0));
`endif

      // Reset in the middle of a catch-up
      load(mk(0, 0, 9'd0, 5'd0, 6'd0, 6'd0), 32'd50);
      cyc(5);
      rst_n = 1'b0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_save", save_state, 0);
      chk("mr_pulse", sec_pulse, 0);
      rd("mr_r4", 3'd4, 8'h00);
      rd("mr_r6", 3'd6, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(3);
      chk("mr_busy_after", busy, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
